ps2_scan_receiver: RTL and testbench
====================================

# ps2_scan_receiver

Deserialises a PS/2 keyboard line (device-driven clock and data) into 16-bit key words for the CPU input buffer. It checks frame parity and stop bits, folds the E0 (extended) and F0 (break) prefix bytes into flag bits, and presents each finished key as a non-zero word for a fixed hold window. It sits directly upstream of the input buffer; that buffer captures any non-zero word on its divided tick.

## Interface
- `HOLD`, 18: cycles a completed word stays on `code` before it returns to 0. Must be at least the consumer tick period and less than 2× that period.
- `TIMEOUT`, 5000: idle `clk` cycles inside a frame before the frame is abandoned.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `code` out 16: key word: [15:10]=0, [9]=extended, [8]=break, [7:0]=scancode. It is 0 when no word is held.
- `valid` out 1: one-cycle pulse in the cycle `code` loads a new word.
- `busy` out 1: high while a frame is in progress (any state other than IDLE).
- `err_cnt` out 8: count of discarded frames (parity, stop or timeout). Saturates at 255.

## Operation
- Input synchronisation: `ps2_clk` and `ps2_data` each pass through 2 flops, plus a third flop on the clock path.
- Falling edge ("fe") = sync2 low and sync3 high. Data is sampled from the data sync2 stage in the fe cycle.
- State machine: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with data=0 (start bit), clear the shift register and bit counter and go to DATA. On fe with data=1, stay in IDLE; this is not an error.
  - DATA: on each fe, shift the data bit in, LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fe, store the bit, then go to STOP.
  - STOP: on fe, the frame is good if the stop bit is 1 and (byte XOR-reduce XOR parity bit)=1, i.e. odd parity. Return to IDLE in all cases.
- Timeout counter: 16 bits. It clears on every fe and on entry to IDLE, and counts in non-IDLE states. When it reaches `TIMEOUT`, go to IDLE, increment `err_cnt`, and clear the prefix flags.
- Good byte handling:
  - E0: set the ext flag. No output.
  - F0: set the brk flag. No output.
  - 00: discard silently, clear both flags, no error count.
  - Any other byte: load code={6'b0, ext, brk, byte}, pulse `valid`, clear both flags, and load the hold counter with `HOLD`.
- Bad frame (parity or stop): increment `err_cnt` (saturating), clear both flags, no output.
- Hold counter: decrements each cycle while non-zero. `code` is forced to 0 in the cycle the counter reaches 0.
- A new word completing while a hold is active overwrites `code` and reloads the counter. The hold does not block reception.

## Timing
- Reset values: `code`=0, `valid`=0, `busy`=0, `err_cnt`=0. Also: state IDLE, flags clear, all sync flops 1 (idle line level), counters 0.
- Reset asserted mid-frame: the partial frame is lost with no error count. Reception resumes at the next start bit after `rst` deasserts.
- A pin falling edge is detected 3 `clk` rising edges after the pin change. `code` and `valid` update 1 cycle after the STOP-state fe, registered.
- `code` stays non-zero for exactly `HOLD` cycles, counted from the cycle `valid` is high.
- `busy` rises the cycle after the start-bit fe and falls the cycle after the stop fe or the timeout.
- A prefix byte followed by a bad frame or a timeout loses the prefix; the next good byte is emitted without flags.
- When fe and timeout fall in the same cycle, fe wins: the counter clears and the bit is accepted.

## Test plan
- Make A: frame 0,[0,0,1,1,1,0,0,0],parity 0,stop 1 (byte 0x1C) -> one `valid` pulse, `code`=0x001C for 18 cycles then 0x0000, `err_cnt`=0.
- Break: F0 then 1C -> single `valid`, `code`=0x011C. No output for the F0 byte.
- Extended break: E0, F0, 75 -> single `valid`, `code`=0x0375. The next frame 1C gives 0x001C, showing the flags cleared.
- Parity error: F0, then 1C with parity 1, then good 1C -> `err_cnt`=1, exactly one `valid`, `code`=0x001C.
- Timeout: start bit + 5 data bits, then `ps2_clk` held high for 5001 cycles -> `busy` falls and `err_cnt`=1. A following good 0x29 frame gives `code`=0x0029.
- Reset mid-frame: assert `rst` after 4 data bits -> all outputs 0 immediately. After deassert, a full 0x1C frame gives 0x001C and `err_cnt` stays 0.

Source files
------------

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard frame deserialiser folding E0/F0 prefixes into held 16-bit key words
module ps2_scan_receiver #(
  parameter int HOLD    = 18,
  parameter int TIMEOUT = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] code,
  output logic        valid,
  output logic        busy,
  output logic [7:0]  err_cnt
);
  localparam int HW = $clog2(HOLD + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        state_q, state_d;
  logic [2:0]    pc_q;
  logic [1:0]    pd_q;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [15:0]   code_q, code_d;
  logic          valid_q, valid_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    err_q, err_d;
  logic          fe, d;
  assign fe = !pc_q[1] && pc_q[2];
  assign d  = pd_q[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 3'b111;
      pd_q    <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      code_q  <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      err_q   <= '0;
    end else begin
      pc_q    <= {pc_q[1:0], ps2_clk};
      pd_q    <= {pd_q[0], ps2_data};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    valid_d = 1'b0;
    hold_d  = hold_q != '0 ? hold_q - HW'(1) : hold_q;
    code_d  = hold_q == HW'(1) ? 16'h0 : code_q;
    err_d   = err_q;
    if (fe) begin
      case (state_q)
        IDLE: if (!d) begin
          state_d = DATA;
          sh_d    = '0;
          cnt_d   = '0;
        end
        DATA: begin
          sh_d    = {d, sh_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = cnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = d;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (d && (^sh_q ^ par_q)) begin
            ext_d = sh_q == 8'hE0 ? 1'b1 : (sh_q == 8'hF0 ? ext_q : 1'b0);
            brk_d = sh_q == 8'hF0 ? 1'b1 : (sh_q == 8'hE0 ? brk_q : 1'b0);
            if (sh_q != 8'hE0 && sh_q != 8'hF0 && sh_q != 8'h00) begin
              code_d  = {6'b0, ext_q, brk_q, sh_q};
              valid_d = 1'b1;
              hold_d  = HW'(HOLD);
            end
          end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            err_d = err_q == 8'hFF ? err_q : err_q + 8'd1;
          end
        end
      endcase
    end else if (state_q != IDLE && tmo_q == 16'(TIMEOUT)) begin
      state_d = IDLE;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      err_d   = err_q == 8'hFF ? err_q : err_q + 8'd1;
    end
    tmo_d = (fe || state_d == IDLE) ? 16'h0 : tmo_q + 16'd1;
  end
  assign code    = code_q;
  assign valid   = valid_q;
  assign busy    = state_q != IDLE;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: frame table plus hand sequences, key words checked through an expected-word queue
module tb_ps2_scan_receiver;
  localparam int HOLD = 18;
  localparam int HALF = 20;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] code;
  logic        valid;
  logic        busy;
  logic [7:0]  err_cnt;
  int checks = 0;
  int failures = 0;
  int run = 0;
  logic [15:0] exp_q[$];
  typedef struct {
    logic [7:0]  b;
    logic        bad_par;
    logic        stop;
    logic        emits;
    logic [15:0] exp;
    logic [7:0]  err;
  } vec_t;
  vec_t v[16];
  ps2_scan_receiver #(.HOLD(HOLD), .TIMEOUT(5000)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .valid(valid), .busy(busy), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) run = 0;
    else begin
      if (valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", code, 16'hxxxx);
        else check("code_on_valid", code, exp_q.pop_front());
        run = 0;
      end
      if (code != 16'h0) run++;
      else if (run != 0) begin
        check("hold_len", 16'(run), 16'(HOLD));
        run = 0;
      end
    end
  end
  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask
  initial begin
    v[0]  = '{8'h1C, 0, 1, 1, 16'h001C, 8'd0};
    v[1]  = '{8'hF0, 0, 1, 0, 16'h0000, 8'd0};
    v[2]  = '{8'h1C, 0, 1, 1, 16'h011C, 8'd0};
    v[3]  = '{8'hE0, 0, 1, 0, 16'h0000, 8'd0};
    v[4]  = '{8'hF0, 0, 1, 0, 16'h0000, 8'd0};
    v[5]  = '{8'h75, 0, 1, 1, 16'h0375, 8'd0};
    v[6]  = '{8'h1C, 0, 1, 1, 16'h001C, 8'd0};
    v[7]  = '{8'hF0, 0, 1, 0, 16'h0000, 8'd0};
    v[8]  = '{8'h1C, 1, 1, 0, 16'h0000, 8'd1};
    v[9]  = '{8'h1C, 0, 1, 1, 16'h001C, 8'd1};
    v[10] = '{8'hE0, 0, 1, 0, 16'h0000, 8'd1};
    v[11] = '{8'h00, 0, 1, 0, 16'h0000, 8'd1};
    v[12] = '{8'h1C, 0, 1, 1, 16'h001C, 8'd1};
    v[13] = '{8'h1C, 0, 0, 0, 16'h0000, 8'd2};
    v[14] = '{8'hE0, 0, 1, 0, 16'h0000, 8'd2};
    v[15] = '{8'h5A, 0, 1, 1, 16'h025A, 8'd2};
    repeat (3) @(negedge clk);
    check("rst_code", code, 16'h0);
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_err", 16'(err_cnt), 16'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (v[i].emits) exp_q.push_back(v[i].exp);
      send_frame(v[i].b, v[i].bad_par, v[i].stop);
      check($sformatf("err_v%0d", i), 16'(err_cnt), 16'(v[i].err));
      check($sformatf("busy_v%0d", i), 16'(busy), 16'h0);
    end
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    repeat (5) @(negedge clk);
    check("busy_partial", 16'(busy), 16'h1);
    repeat (5010) @(negedge clk);
    check("busy_timeout", 16'(busy), 16'h0);
    check("err_timeout", 16'(err_cnt), 16'd3);
    exp_q.push_back(16'h0029);
    send_frame(8'h29, 1'b0, 1'b1);
    check("err_after_timeout", 16'(err_cnt), 16'd3);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (5) @(negedge clk);
    check("busy_before_rst", 16'(busy), 16'h1);
    rst = 1'b1;
    #1;
    check("midrst_code", code, 16'h0);
    check("midrst_valid", 16'(valid), 16'h0);
    check("midrst_busy", 16'(busy), 16'h0);
    check("midrst_err", 16'(err_cnt), 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back(16'h001C);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("err_after_rst", 16'(err_cnt), 16'h0);
    repeat (HOLD + 5) @(negedge clk);
    check("code_idle_end", code, 16'h0);
    check("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
